// File: rtl/i2c_reg_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave_if
// Configuration-side bus between the I2C register target and the DSP
// configuration logic.
//   regs_flat : register bank, reg k at bits [8k+7:8k]
//   wr_en     : one-cycle strobe when a register is written from I2C
//   wr_addr   : register index written (valid with wr_en)
//   wr_data   : byte written (valid with wr_en)
//   busy      : target addressed, from address match until STOP/START
//   rd_strobe : one-cycle strobe when a byte is loaded for transmission
// Modports: slave (driven by the I2C target), master (consumer side).
// -----------------------------------------------------------------------------
interface i2c_reg_slave_if #(
  parameter int NUM_REGS = 16
);
  localparam int PTR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  logic [8*NUM_REGS-1:0] regs_flat;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_addr;
  logic [7:0]            wr_data;
  logic                  busy;
  logic                  rd_strobe;

  modport slave (
    output regs_flat, wr_en, wr_addr, wr_data, busy, rd_strobe
  );

  modport master (
    input regs_flat, wr_en, wr_addr, wr_data, busy, rd_strobe
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave
// I2C target with an internal bank of NUM_REGS 8-bit registers. Decodes
// START / repeated START / STOP, matches SLAVE_ADDR, takes a pointer byte
// on writes, and supports burst writes and burst reads with pointer
// auto-increment (wrapping at NUM_REGS). SCL is never stretched.
// Ports:
//   clk, rst_n : system clock (>= 16x SCL), async active-low reset
//   scl        : I2C clock input
//   sda        : I2C data, open-drain (pulled low or released)
//   cfg        : register bank / write strobe / status bus (slave modport)
// -----------------------------------------------------------------------------
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scl,
  inout  wire            sda,
  i2c_reg_slave_if.slave cfg
);

  localparam int               PTR_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam int               REGS_W   = 8 * NUM_REGS;
  localparam logic [2:0]       FILT_MAX = 3'(FILTER_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_IGNORE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 = SCL, index 1 = SDA.
  // A level change is accepted only after the synchronized input has
  // disagreed with the filtered value for FILTER_LEN consecutive samples.
  // ---------------------------------------------------------------------------
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d, filt_prev_q;
  logic [1:0][2:0] fcnt_q, fcnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_MAX) filt_d[i] = sync2_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + 3'd1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      fcnt_q      <= '0;
    end else begin
      sync1_q     <= {sda, scl};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  =  filt_q[0] & ~filt_prev_q[0];
  assign scl_fall  = ~filt_q[0] &  filt_prev_q[0];
  // SCL must be high both before and after the SDA transition.
  assign start_det = ~filt_q[1] &  filt_prev_q[1] & scl_f & filt_prev_q[0];
  assign stop_det  =  filt_q[1] & ~filt_prev_q[1] & scl_f & filt_prev_q[0];

  // ---------------------------------------------------------------------------
  // Protocol FSM and register bank
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;   // counts 7..0, bit 3 set = byte done
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ptr_phase_q, ptr_phase_d;
  logic             mack_q, mack_d;         // master ACK bit sampled in TX_ACK
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_strobe_q, rd_strobe_d;
  logic [REGS_W-1:0] regs_q, regs_d;

  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic             load_tx;

  assign rd_byte = regs_q[{ptr_q, 3'b000} +: 8];
  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_byte_d   = tx_byte_q;
    ptr_d       = ptr_q;
    ptr_phase_d = ptr_phase_q;
    mack_d      = mack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    regs_d      = regs_q;
    load_tx     = 1'b0;

    // Bus conditions win over bit sampling in the same cycle.
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd7;
      shift_d   = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise && !bit_cnt_q[3]) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall && bit_cnt_q[3]) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (shift_q[0]) begin
              load_tx = 1'b1;
            end else begin
              state_d     = ST_RX;
              bit_cnt_d   = 4'd7;
              ptr_phase_d = 1'b1;
              sda_oe_d    = 1'b0;
            end
          end
        end

        ST_RX: begin
          if (scl_rise && !bit_cnt_q[3]) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall && bit_cnt_q[3]) begin
            state_d = ST_RX_ACK;
            if (ptr_phase_q) begin
              // Out-of-range pointer is NACKed and the next byte is again
              // taken as a pointer.
              if (32'(shift_q) < NUM_REGS) begin
                ptr_d       = shift_q[PTR_W-1:0];
                ptr_phase_d = 1'b0;
                sda_oe_d    = 1'b1;
              end
            end else begin
              regs_d[{ptr_q, 3'b000} +: 8] = shift_q;
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_q;
              ptr_d     = ptr_inc;
              sda_oe_d  = 1'b1;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d   = ST_RX;
            bit_cnt_d = 4'd7;
            sda_oe_d  = 1'b0;
          end
        end

        ST_TX: begin
          if (scl_rise && !bit_cnt_q[3]) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q[3]) begin
              state_d  = ST_TX_ACK;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_inc;
            end else begin
              sda_oe_d = ~tx_byte_q[bit_cnt_q[2:0]];
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = sda_f;
          end else if (scl_fall) begin
            if (!mack_q) load_tx = 1'b1;
            else         state_d = ST_IGNORE;
          end
        end

        default: ;  // IDLE and IGNORE leave only through START or STOP
      endcase
    end

    // Shared by the first read byte and every ACKed follow-on byte.
    if (load_tx) begin
      state_d     = ST_TX;
      bit_cnt_d   = 4'd7;
      tx_byte_d   = rd_byte;
      sda_oe_d    = ~rd_byte[7];
      rd_strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd7;
      shift_q     <= '0;
      tx_byte_q   <= '0;
      ptr_q       <= '0;
      ptr_phase_q <= 1'b0;
      mack_q      <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      // NOTE: the register bank is a flop array visible to downstream logic,
      // so it is reset to a known value rather than left as uninitialized RAM.
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_byte_q   <= tx_byte_d;
      ptr_q       <= ptr_d;
      ptr_phase_q <= ptr_phase_d;
      mack_q      <= mack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      regs_q      <= regs_d;
    end
  end

  // Open-drain: only ever pull low; reset clears sda_oe_q asynchronously.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign cfg.regs_flat = regs_q;
  assign cfg.wr_en     = wr_en_q;
  assign cfg.wr_addr   = wr_addr_q;
  assign cfg.wr_data   = wr_data_q;
  assign cfg.busy      = busy_q;
  assign cfg.rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_slave
// Bit-banged I2C master driving i2c_reg_slave (NUM_REGS=16, FILTER_LEN=3).
// Expected register writes are queued as stimulus is issued; a monitor pops
// and compares on every wr_en pulse. Bus-level responses (ACK bits, read
// data, SDA release) are compared directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_i2c_reg_slave;

  localparam int NUM_REGS = 16;
  localparam int Q        = 100;   // quarter SCL period = 10 clk cycles

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic scl      = 1'b1;
  logic m_sda_oe = 1'b0;
  wire  sda;

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_slave_if #(.NUM_REGS(NUM_REGS)) cfg ();

  i2c_reg_slave #(
    .SLAVE_ADDR(7'h50),
    .NUM_REGS  (NUM_REGS),
    .FILTER_LEN(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .scl  (scl),
    .sda  (sda),
    .cfg  (cfg)
  );

  always #5 clk = ~clk;

  int   checks     = 0;
  int   fails      = 0;
  int   rd_cnt     = 0;
  int   quiet_viol = 0;
  logic watch_quiet = 1'b0;
  wr_t  wr_exp_q[$];
  wr_t  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input int k);
    return cfg.regs_flat[8*k +: 8];
  endfunction

  // Scoreboard monitor: every wr_en pulse must match the next queued write.
  always @(negedge clk) begin
    if (rst_n && cfg.wr_en) begin
      checks++;
      if (wr_exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_wr: got addr %0d data 0x%0h expected no write",
                 cfg.wr_addr, cfg.wr_data);
      end else begin
        mon_e = wr_exp_q.pop_front();
        if (cfg.wr_addr !== mon_e.addr || cfg.wr_data !== mon_e.data ||
            reg_of(int'(mon_e.addr)) !== mon_e.data) begin
          fails++;
          $display("FAIL wr_port: got addr %0d data 0x%0h reg 0x%0h expected addr %0d data 0x%0h",
                   cfg.wr_addr, cfg.wr_data, reg_of(int'(cfg.wr_addr)), mon_e.addr, mon_e.data);
        end
      end
    end
    if (rst_n && cfg.rd_strobe) rd_cnt++;
    if (watch_quiet && ((!m_sda_oe && sda === 1'b0) || cfg.busy)) quiet_viol++;
  end

  // ---------------------------------------------------------------------------
  // Master bus primitives. Every call starts and ends with SCL low Q after
  // its falling edge (except start from idle), so SDA only moves while SCL
  // is low.
  // ---------------------------------------------------------------------------
  task automatic clock_bit(input logic drive_low, input logic glitch, output logic sampled);
    m_sda_oe = drive_low;
    if (glitch) begin
      #(Q/2); scl = 1'b1; #10; scl = 1'b0; #(Q/2 - 10);
    end else begin
      #Q;
    end
    scl = 1'b1; #Q;
    sampled = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      m_sda_oe = 1'b0; #Q;
      scl = 1'b1;      #Q;
    end
    m_sda_oe = 1'b1; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic stop_cond();
    m_sda_oe = 1'b1; #Q;
    scl = 1'b1;      #Q;
    m_sda_oe = 1'b0; #Q;
  endtask

  // ack = 1 when the target pulled SDA low in the 9th clock.
  task automatic write_byte(input logic [7:0] b, output logic ack, input int glitch_bit = -1);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], (i == glitch_bit), s);
    clock_bit(1'b0, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, 1'b0, s);
      b[i] = s;
    end
    clock_bit(master_ack, 1'b0, s);
    m_sda_oe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] b;
    int         rd_base;

    #52; rst_n = 1'b1; #100;

    // Reset state
    check("reset_regs_flat_nonzero", 32'(|cfg.regs_flat), 32'd0);
    check("reset_busy",      32'(cfg.busy),      32'd0);
    check("reset_wr_en",     32'(cfg.wr_en),     32'd0);
    check("reset_rd_strobe", 32'(cfg.rd_strobe), 32'd0);
    check("reset_sda",       32'(sda),           32'd1);

    // Write burst: START A0 03 11 22 STOP
    start_cond();
    write_byte(8'hA0, ack); check("wb_addr_ack", 32'(ack), 32'd1);
    check("wb_busy_high", 32'(cfg.busy), 32'd1);
    write_byte(8'h03, ack); check("wb_ptr_ack", 32'(ack), 32'd1);
    wr_exp_q.push_back('{addr: 4'd3, data: 8'h11});
    write_byte(8'h11, ack); check("wb_d0_ack", 32'(ack), 32'd1);
    wr_exp_q.push_back('{addr: 4'd4, data: 8'h22});
    write_byte(8'h22, ack); check("wb_d1_ack", 32'(ack), 32'd1);
    stop_cond();
    check("wb_reg3", 32'(reg_of(3)), 32'h11);
    check("wb_reg4", 32'(reg_of(4)), 32'h22);
    check("wb_busy_after_stop", 32'(cfg.busy), 32'd0);

    // Random read: START A0 03 Sr A1, read with ACK, ACK, NACK
    rd_base = rd_cnt;
    start_cond();
    write_byte(8'hA0, ack); check("rr_addr_w_ack", 32'(ack), 32'd1);
    write_byte(8'h03, ack); check("rr_ptr_ack", 32'(ack), 32'd1);
    start_cond();
    write_byte(8'hA1, ack); check("rr_addr_r_ack", 32'(ack), 32'd1);
    read_byte(1'b1, b); check("rr_byte0", 32'(b), 32'h11);
    read_byte(1'b1, b); check("rr_byte1", 32'(b), 32'h22);
    read_byte(1'b0, b); check("rr_byte2", 32'(b), 32'h00);
    s = sda;            check("rr_sda_released_after_nack", 32'(s), 32'd1);
    stop_cond();
    check("rr_rd_strobe_count", 32'(rd_cnt - rd_base), 32'd3);

    // Wrap and range: pointer 0F, write AA BB; then pointer 10 NACKed,
    // pointer phase retained so 02 is a pointer and 66 lands in reg 2.
    start_cond();
    write_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h0F, ack); check("wr_ptr15_ack", 32'(ack), 32'd1);
    wr_exp_q.push_back('{addr: 4'd15, data: 8'hAA});
    write_byte(8'hAA, ack);
    wr_exp_q.push_back('{addr: 4'd0, data: 8'hBB});
    write_byte(8'hBB, ack); check("wr_wrap_ack", 32'(ack), 32'd1);
    stop_cond();
    check("wr_reg15", 32'(reg_of(15)), 32'hAA);
    check("wr_reg0",  32'(reg_of(0)),  32'hBB);
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack); check("wr_ptr16_nack", 32'(ack), 32'd0);
    write_byte(8'h02, ack); check("wr_ptr2_ack", 32'(ack), 32'd1);
    wr_exp_q.push_back('{addr: 4'd2, data: 8'h66});
    write_byte(8'h66, ack);
    stop_cond();
    check("wr_reg2", 32'(reg_of(2)), 32'h66);

    // Address mismatch, then a valid transaction
    watch_quiet = 1'b1;
    start_cond();
    write_byte(8'hA2, ack); check("mm_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h55, ack); check("mm_data_nack", 32'(ack), 32'd0);
    stop_cond();
    watch_quiet = 1'b0;
    check("mm_quiet_violations", 32'(quiet_viol), 32'd0);
    start_cond();
    write_byte(8'hA0, ack); check("mm_next_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h07, ack);
    wr_exp_q.push_back('{addr: 4'd7, data: 8'h5A});
    write_byte(8'h5A, ack);
    stop_cond();
    check("mm_next_reg7", 32'(reg_of(7)), 32'h5A);

    // SCL glitch during a data byte
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h08, ack);
    wr_exp_q.push_back('{addr: 4'd8, data: 8'h3C});
    write_byte(8'h3C, ack, 4); check("gl_data_ack", 32'(ack), 32'd1);
    stop_cond();
    check("gl_reg8", 32'(reg_of(8)), 32'h3C);

    // STOP after 4 data bits leaves the target register unchanged
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h09, ack); check("ab_ptr_ack", 32'(ack), 32'd1);
    clock_bit(1'b0, 1'b0, s);
    clock_bit(1'b1, 1'b0, s);
    clock_bit(1'b0, 1'b0, s);
    clock_bit(1'b0, 1'b0, s);
    stop_cond();
    check("ab_reg9", 32'(reg_of(9)), 32'h00);

    // Async reset while the target drives the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) clock_bit(~(8'hA0 >> i) & 1'b1, 1'b0, s);
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1;      #Q;
    s = sda;         check("ar_ack_driven", 32'(s), 32'd0);
    rst_n = 1'b0;    #1;
    check("ar_sda_released", 32'(sda), 32'd1);
    check("ar_regs_cleared", 32'(|cfg.regs_flat), 32'd0);
    check("ar_busy_cleared", 32'(cfg.busy), 32'd0);
    #9;
    #Q; rst_n = 1'b1; #(2*Q);

    check("scoreboard_drained", 32'(wr_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
